// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, IR field positions, control states and alu_op bit indices.
// Pure declarations; no timing or flow control involved.
package cpu_pkg;

   localparam int IR_W    = 32;
   localparam int NREG    = 16;
   localparam int ALU_W   = 13;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ROR  = 5'b00111;
   localparam logic [4:0] OP_ROL  = 5'b01000;
   localparam logic [4:0] OP_SHR  = 5'b01001;
   localparam logic [4:0] OP_SHRA = 5'b01010;
   localparam logic [4:0] OP_SHL  = 5'b01011;
   localparam logic [4:0] OP_DIV  = 5'b01111;
   localparam logic [4:0] OP_MUL  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;

   // alu_op bit positions, shared with the datapath ALU
   localparam int ALU_AND  = 0;
   localparam int ALU_OR   = 1;
   localparam int ALU_ADD  = 2;
   localparam int ALU_SUB  = 3;
   localparam int ALU_MUL  = 4;
   localparam int ALU_DIV  = 5;
   localparam int ALU_SHR  = 6;
   localparam int ALU_SHRA = 7;
   localparam int ALU_SHL  = 8;
   localparam int ALU_ROR  = 9;
   localparam int ALU_ROL  = 10;
   localparam int ALU_NEG  = 11;
   localparam int ALU_NOT  = 12;

   typedef enum logic [2:0] {
      S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
   } state_e;

   typedef enum logic [1:0] {
      CLS_ALU3, CLS_HILO, CLS_UNARY, CLS_ILLEGAL
   } instr_class_e;

   function automatic logic [NREG-1:0] reg_onehot(input logic [3:0] idx);
      return {{(NREG-1){1'b0}}, 1'b1} << idx;
   endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational IR decoder: instruction class, one-hot ALU operation and one-hot register selects.
// Zero latency; no flow control.
module instr_decode
   import cpu_pkg::*;
(
   input  logic [IR_W-1:0]  ir_i,
   output instr_class_e     cls_o,
   output logic [ALU_W-1:0] alu_op_o,
   output logic [NREG-1:0]  ra_oh_o,
   output logic [NREG-1:0]  rb_oh_o,
   output logic [NREG-1:0]  rc_oh_o
);

   logic [4:0] opcode;
   logic       unused_ir_low;

   assign opcode        = ir_i[OPC_MSB:OPC_LSB];
   assign ra_oh_o       = reg_onehot(ir_i[RA_MSB:RA_LSB]);
   assign rb_oh_o       = reg_onehot(ir_i[RB_MSB:RB_LSB]);
   assign rc_oh_o       = reg_onehot(ir_i[RC_MSB:RC_LSB]);
   assign unused_ir_low = ^ir_i[RC_LSB-1:0];

   always_comb begin
      cls_o    = CLS_ILLEGAL;
      alu_op_o = '0;
      case (opcode)
         OP_ADD:  begin cls_o = CLS_ALU3;  alu_op_o[ALU_ADD]  = 1'b1; end
         OP_SUB:  begin cls_o = CLS_ALU3;  alu_op_o[ALU_SUB]  = 1'b1; end
         OP_AND:  begin cls_o = CLS_ALU3;  alu_op_o[ALU_AND]  = 1'b1; end
         OP_OR:   begin cls_o = CLS_ALU3;  alu_op_o[ALU_OR]   = 1'b1; end
         OP_ROR:  begin cls_o = CLS_ALU3;  alu_op_o[ALU_ROR]  = 1'b1; end
         OP_ROL:  begin cls_o = CLS_ALU3;  alu_op_o[ALU_ROL]  = 1'b1; end
         OP_SHR:  begin cls_o = CLS_ALU3;  alu_op_o[ALU_SHR]  = 1'b1; end
         OP_SHRA: begin cls_o = CLS_ALU3;  alu_op_o[ALU_SHRA] = 1'b1; end
         OP_SHL:  begin cls_o = CLS_ALU3;  alu_op_o[ALU_SHL]  = 1'b1; end
         OP_DIV:  begin cls_o = CLS_HILO;  alu_op_o[ALU_DIV]  = 1'b1; end
         OP_MUL:  begin cls_o = CLS_HILO;  alu_op_o[ALU_MUL]  = 1'b1; end
         OP_NEG:  begin cls_o = CLS_UNARY; alu_op_o[ALU_NEG]  = 1'b1; end
         OP_NOT:  begin cls_o = CLS_UNARY; alu_op_o[ALU_NOT]  = 1'b1; end
         default: begin cls_o = CLS_ILLEGAL; end
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Hardwired T-state sequencer driving the datapath strobes; Moore outputs, one cycle per T-state.
// stop is honoured only in the last execute cycle; no other flow control.
module control_unit
   import cpu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             stop,
   input  logic [IR_W-1:0]  IR,
   output logic [NREG-1:0]  Rin,
   output logic [NREG-1:0]  Rout,
   output logic             PCout,
   output logic             IncPC,
   output logic             PCin,
   output logic             MARin,
   output logic             Read,
   output logic             MDRin,
   output logic             MDRout,
   output logic             IRin,
   output logic             Yin,
   output logic             Zin,
   output logic             Zlowout,
   output logic             Zhighout,
   output logic             HIin,
   output logic             LOin,
   output logic [ALU_W-1:0] alu_op,
   output logic             run,
   output logic             illegal
);

   state_e           state_q, state_d;
   logic             illegal_q, illegal_d;
   instr_class_e     cls;
   logic [ALU_W-1:0] dec_alu;
   logic [NREG-1:0]  ra_oh, rb_oh, rc_oh;
   state_e           end_tgt;

   instr_decode u_decode (
      .ir_i     (IR),
      .cls_o    (cls),
      .alu_op_o (dec_alu),
      .ra_oh_o  (ra_oh),
      .rb_oh_o  (rb_oh),
      .rc_oh_o  (rc_oh)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_T0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // Decoded class is only consulted from T3 onward, once IR holds the fetched word
   always_comb begin
      end_tgt   = stop ? S_HALT : S_T0;
      state_d   = state_q;
      illegal_d = illegal_q | ((state_q == S_T3) && (cls == CLS_ILLEGAL));
      case (state_q)
         S_T0:    state_d = S_T1;
         S_T1:    state_d = S_T2;
         S_T2:    state_d = S_T3;
         S_T3:    state_d = (cls == CLS_ILLEGAL) ? end_tgt : S_T4;
         S_T4:    state_d = (cls == CLS_UNARY)   ? end_tgt : S_T5;
         S_T5:    state_d = (cls == CLS_ALU3)    ? end_tgt : S_T6;
         S_T6:    state_d = end_tgt;
         S_HALT:  state_d = stop ? S_HALT : S_T0;
         default: state_d = S_T0;
      endcase
   end

   always_comb begin
      Rin      = '0;
      Rout     = '0;
      PCout    = 1'b0;
      IncPC    = 1'b0;
      PCin     = 1'b0;
      MARin    = 1'b0;
      Read     = 1'b0;
      MDRin    = 1'b0;
      MDRout   = 1'b0;
      IRin     = 1'b0;
      Yin      = 1'b0;
      Zin      = 1'b0;
      Zlowout  = 1'b0;
      Zhighout = 1'b0;
      HIin     = 1'b0;
      LOin     = 1'b0;
      alu_op   = '0;
      run      = reset || (state_q != S_HALT);
      illegal  = illegal_q && !reset;
      if (!reset) begin
         case (state_q)
            S_T0: begin
               PCout = 1'b1;
               MARin = 1'b1;
               IncPC = 1'b1;
               PCin  = 1'b1;
            end
            S_T1: begin
               Read  = 1'b1;
               MDRin = 1'b1;
            end
            S_T2: begin
               MDRout = 1'b1;
               IRin   = 1'b1;
            end
            S_T3: begin
               if (cls == CLS_UNARY) begin
                  Rout   = rb_oh;
                  alu_op = dec_alu;
                  Zin    = 1'b1;
               end else if (cls != CLS_ILLEGAL) begin
                  Rout = rb_oh;
                  Yin  = 1'b1;
               end
            end
            S_T4: begin
               if (cls == CLS_UNARY) begin
                  Zlowout = 1'b1;
                  Rin     = ra_oh;
               end else if (cls != CLS_ILLEGAL) begin
                  Rout   = rc_oh;
                  alu_op = dec_alu;
                  Zin    = 1'b1;
               end
            end
            S_T5: begin
               if (cls == CLS_ALU3) begin
                  Zlowout = 1'b1;
                  Rin     = ra_oh;
               end else if (cls == CLS_HILO) begin
                  Zlowout = 1'b1;
                  LOin    = 1'b1;
               end
            end
            S_T6: begin
               if (cls == CLS_HILO) begin
                  Zhighout = 1'b1;
                  HIin     = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench: directed instruction walk-throughs plus randomized instruction streams
// compared each cycle against a cycle-count model of the sequencer.
module tb_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stop;
   logic [31:0] IR;
   logic [15:0] Rin, Rout;
   logic        PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin;
   logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
   logic [12:0] alu_op;
   logic        run, illegal;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic pcout, incpc, pcin, marin, read, mdrin, mdrout, irin;
      logic yin, zin, zlowout, zhighout, hiin, loin;
      logic [12:0] alu;
      logic run;
      logic illegal;
   } obs_t;

   control_unit dut (
      .clk      (clk),
      .reset    (reset),
      .stop     (stop),
      .IR       (IR),
      .Rin      (Rin),
      .Rout     (Rout),
      .PCout    (PCout),
      .IncPC    (IncPC),
      .PCin     (PCin),
      .MARin    (MARin),
      .Read     (Read),
      .MDRin    (MDRin),
      .MDRout   (MDRout),
      .IRin     (IRin),
      .Yin      (Yin),
      .Zin      (Zin),
      .Zlowout  (Zlowout),
      .Zhighout (Zhighout),
      .HIin     (HIin),
      .LOin     (LOin),
      .alu_op   (alu_op),
      .run      (run),
      .illegal  (illegal)
   );

   always #5 clk = ~clk;

   // Model: position k within the instruction (0 = T0), halt flag, sticky illegal
   int m_k    = 0;
   bit m_halt = 1'b0;
   bit m_ill  = 1'b0;

   // class: 0 ALU3, 1 HILO, 2 UNARY, 3 illegal
   function automatic int cls_of(input logic [4:0] op);
      case (op)
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: return 0;
         5'd15, 5'd16: return 1;
         5'd17, 5'd18: return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int alu_bit(input logic [4:0] op);
      case (op)
         5'd5:  return 0;
         5'd6:  return 1;
         5'd3:  return 2;
         5'd4:  return 3;
         5'd16: return 4;
         5'd15: return 5;
         5'd9:  return 6;
         5'd10: return 7;
         5'd11: return 8;
         5'd7:  return 9;
         5'd8:  return 10;
         5'd17: return 11;
         5'd18: return 12;
         default: return -1;
      endcase
   endfunction

   function automatic int cycles_of(input int c);
      case (c)
         0: return 6;
         1: return 7;
         2: return 5;
         default: return 4;
      endcase
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_k    <= 0;
         m_halt <= 1'b0;
         m_ill  <= 1'b0;
      end else if (m_halt) begin
         if (!stop) begin
            m_halt <= 1'b0;
            m_k    <= 0;
         end
      end else if (m_k == cycles_of(cls_of(IR[31:27])) - 1) begin
         if (cls_of(IR[31:27]) == 3) m_ill <= 1'b1;
         if (stop) m_halt <= 1'b1;
         m_k <= 0;
      end else begin
         m_k <= m_k + 1;
      end
   end

   function automatic obs_t model_out();
      obs_t        e;
      int          c, s, ab;
      logic [15:0] ra_oh, rb_oh, rc_oh;
      logic [12:0] alu;
      e     = '0;
      c     = cls_of(IR[31:27]);
      ab    = alu_bit(IR[31:27]);
      alu   = (ab < 0) ? 13'd0 : (13'd1 << ab);
      ra_oh = 16'd1 << IR[26:23];
      rb_oh = 16'd1 << IR[22:19];
      rc_oh = 16'd1 << IR[18:15];
      e.run     = reset || !m_halt;
      e.illegal = m_ill && !reset;
      if (!reset && !m_halt) begin
         if (m_k == 0) begin
            e.pcout = 1; e.marin = 1; e.incpc = 1; e.pcin = 1;
         end else if (m_k == 1) begin
            e.read = 1; e.mdrin = 1;
         end else if (m_k == 2) begin
            e.mdrout = 1; e.irin = 1;
         end else begin
            s = m_k - 3;
            if (c == 2) begin
               if (s == 0) begin e.rout = rb_oh; e.alu = alu; e.zin = 1; end
               else if (s == 1) begin e.zlowout = 1; e.rin = ra_oh; end
            end else if (c < 2) begin
               case (s)
                  0: begin e.rout = rb_oh; e.yin = 1; end
                  1: begin e.rout = rc_oh; e.alu = alu; e.zin = 1; end
                  2: begin
                     e.zlowout = 1;
                     if (c == 0) e.rin = ra_oh;
                     else e.loin = 1;
                  end
                  3: begin e.zhighout = 1; e.hiin = 1; end
                  default: ;
               endcase
            end
         end
      end
      return e;
   endfunction

   function automatic obs_t dut_out();
      obs_t g;
      g.rin = Rin; g.rout = Rout;
      g.pcout = PCout; g.incpc = IncPC; g.pcin = PCin; g.marin = MARin;
      g.read = Read; g.mdrin = MDRin; g.mdrout = MDRout; g.irin = IRin;
      g.yin = Yin; g.zin = Zin; g.zlowout = Zlowout; g.zhighout = Zhighout;
      g.hiin = HIin; g.loin = LOin; g.alu = alu_op;
      g.run = run; g.illegal = illegal;
      return g;
   endfunction

   always @(negedge clk) begin
      obs_t e, g;
      int   drivers;
      e = model_out();
      g = dut_out();
      n_checks++;
      if (g !== e) begin
         n_fail++;
         $display("FAIL cycle_compare t=%0t: got %h expected %h", $time, g, e);
      end
      drivers = $countones(Rout) + int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout);
      n_checks++;
      if (drivers > 1 || (Rin != 16'd0 && Rout != 16'd0)) begin
         n_fail++;
         $display("FAIL bus_exclusive t=%0t: drivers %0d Rin %h Rout %h, required <=1 driver", $time, drivers, Rin, Rout);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic any_strobe();
      return (Rin != 0) || (Rout != 0) || (alu_op != 0) ||
             PCout || IncPC || PCin || MARin || Read || MDRin || MDRout || IRin ||
             Yin || Zin || Zlowout || Zhighout || HIin || LOin;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0] legal [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                                 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(0, 7) != 0) w[31:27] = legal[$urandom_range(0, 12)];
      return w;
   endfunction

   initial begin
      reset = 1'b1;
      stop  = 1'b0;
      IR    = 32'h221B8000;
      repeat (3) step();
      #1;
      chk("reset_run", 32'(run), 32'd1);
      chk("reset_strobes", 32'(any_strobe()), 32'd0);
      chk("reset_illegal", 32'(illegal), 32'd0);

      // SUB R4,R3,R7
      reset = 1'b0;
      #1; chk("sub_t0_pcout", 32'(PCout), 32'd1);
      step(); step(); step();
      #1; chk("sub_t3_rout", 32'(Rout), 32'h0008); chk("sub_t3_yin", 32'(Yin), 32'd1);
      step();
      #1; chk("sub_t4_rout", 32'(Rout), 32'h0080); chk("sub_t4_alu", 32'(alu_op), 32'h0008);
      chk("sub_t4_zin", 32'(Zin), 32'd1);
      step();
      #1; chk("sub_t5_zlow", 32'(Zlowout), 32'd1); chk("sub_t5_rin", 32'(Rin), 32'h0010);
      step();
      #1; chk("sub_next_t0", 32'(PCout), 32'd1);

      // MUL R3,R1
      IR = 32'h80188000;
      step(); step(); step();
      #1; chk("mul_t3_rout", 32'(Rout), 32'h0008);
      step();
      #1; chk("mul_t4_rout", 32'(Rout), 32'h0002); chk("mul_t4_alu", 32'(alu_op), 32'h0010);
      step();
      #1; chk("mul_t5_zlo_lo", 32'({Zlowout, LOin}), 32'd3);
      step();
      #1; chk("mul_t6_zhi_hi", 32'({Zhighout, HIin}), 32'd3);
      step();
      #1; chk("mul_next_t0", 32'(PCout), 32'd1);

      // NEG R2,R5
      IR = 32'h89280000;
      step(); step(); step();
      #1; chk("neg_t3_rout", 32'(Rout), 32'h0020); chk("neg_t3_alu", 32'(alu_op), 32'h0800);
      chk("neg_t3_zin", 32'(Zin), 32'd1);
      step();
      #1; chk("neg_t4_zlow", 32'(Zlowout), 32'd1); chk("neg_t4_rin", 32'(Rin), 32'h0004);
      step();
      #1; chk("neg_next_t0", 32'(PCout), 32'd1);

      // Illegal opcode
      IR = 32'hF8000000;
      step(); step(); step();
      #1; chk("ill_t3_flag", 32'(illegal), 32'd0); chk("ill_t3_strobes", 32'(any_strobe()), 32'd0);
      step();
      #1; chk("ill_next_t0", 32'(PCout), 32'd1); chk("ill_sticky", 32'(illegal), 32'd1);

      // ADD R0,R0,R0 with an early stop pulse, then stop in T5
      IR = 32'h18000000;
      step();
      stop = 1'b1;
      step();
      stop = 1'b0;
      step(); step(); step();
      stop = 1'b1;
      #1; chk("add_t5_rin", 32'(Rin), 32'h0001); chk("add_t5_ill", 32'(illegal), 32'd1);
      step();
      #1; chk("halt_run", 32'(run), 32'd0); chk("halt_strobes", 32'(any_strobe()), 32'd0);
      step();
      #1; chk("halt_hold", 32'(run), 32'd0);
      stop = 1'b0;
      step();
      #1; chk("halt_exit_t0", 32'(PCout), 32'd1); chk("halt_exit_run", 32'(run), 32'd1);

      // Reset during T4 of SUB
      IR = 32'h221B8000;
      step(); step(); step(); step();
      reset = 1'b1;
      #1; chk("rst_t4_strobes", 32'(any_strobe()), 32'd0);
      step();
      #1; chk("rst_next_strobes", 32'(any_strobe()), 32'd0); chk("rst_illegal", 32'(illegal), 32'd0);
      reset = 1'b0;
      #1; chk("rst_resume_t0", 32'(PCout), 32'd1);
      repeat (6) step();
      #1; chk("rst_sub_done_t0", 32'(PCout), 32'd1);

      // Randomized streams: garbage IR during fetch, real instruction from T3
      for (int i = 0; i < 3000; i++) begin
         step();
         reset = ($urandom_range(0, 99) == 0);
         stop  = ($urandom_range(0, 9) == 0);
         if (!m_halt && m_k == 0) IR = $urandom;
         if (!m_halt && m_k == 3) IR = rand_instr();
      end
      reset = 1'b0;
      stop  = 1'b0;
      repeat (10) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
